// File: rtl/mant_mult_seq_if.sv
// Handshake and data bundle for the sequential mantissa multiplier.
// The master side issues start with operands; the slave side reports busy/done/product.
interface mant_mult_seq_if #(
   parameter int N = 32
) ();
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [63:0]  product;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output product
   );
endinterface

// File: rtl/mant_mult_seq.sv
// Sequential unsigned shift-and-add multiplier (N-bit operands, 64-bit product).
// One operation takes N RUN cycles plus one DONE cycle; a single 64-bit
// recursive-doubling (parallel-prefix) adder does every accumulation.

// 64-bit adder built from six doubling levels of generate/propagate prefixes.
module recursive_doubling_add64 (
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   output logic [63:0] sum_o,
   output logic        cout_o
);
   logic [63:0] g_base;
   logic [63:0] p_base;
   logic [63:0] p_top_unused;

   assign g_base = a_i & b_i;
   assign p_base = a_i ^ b_i;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_lvl
         // Span of the prefix combine doubles at every level: 1, 2, 4, ... 32.
         localparam int          D        = 1 << gi;
         localparam logic [63:0] LOW_MASK = (64'd1 << D) - 64'd1;
         logic [63:0] g_in;
         logic [63:0] p_in;
         logic [63:0] g_out;
         logic [63:0] p_out;

         if (gi == 0) begin : g_first
            assign g_in = g_base;
            assign p_in = p_base;
         end else begin : g_chain
            assign g_in = g_lvl[gi-1].g_out;
            assign p_in = g_lvl[gi-1].p_out;
         end

         // Positions below the span have no partner and pass through unchanged.
         assign g_out = g_in | (p_in & (g_in << D));
         assign p_out = p_in & ((p_in << D) | LOW_MASK);
      end
   endgenerate

   // Group propagate of the final level is not needed for a carry-in-free add.
   assign p_top_unused = g_lvl[5].p_out;

   assign sum_o  = p_base ^ {g_lvl[5].g_out[62:0], 1'b0};
   assign cout_o = g_lvl[5].g_out[63];
endmodule

module mant_mult_seq #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mant_mult_seq_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [5:0] CNT_LAST = 6'(N - 1);

   state_t       state_q;
   logic [63:0]  mcand_q;
   logic [N-1:0] mplier_q;
   logic [63:0]  acc_q;
   logic [5:0]   cnt_q;
   logic [63:0]  product_q;
   logic         busy_q;
   logic         done_q;

   logic [63:0]  sum;
   logic [63:0]  acc_d;
   logic [63:0]  mcand_d;
   logic [N-1:0] mplier_d;
   logic [5:0]   cnt_d;

   // The accumulation never overflows 64 bits while running, so carry-out is dropped.
   logic         adder_cout_unused;

   // Adder operands are hard-wired; its result only matters in RUN.
   recursive_doubling_add64 u_adder (
      .a_i    (acc_q),
      .b_i    (mcand_q),
      .sum_o  (sum),
      .cout_o (adder_cout_unused)
   );

   // Next-state datapath for one shift-and-add step.
   always_comb begin
      acc_d    = mplier_q[0] ? sum : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 6'd1;
   end

   // Control FSM and datapath registers; busy/done are registered with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  mcand_q  <= 64'(bus.a);
                  mplier_q <= bus.b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
               end
            end
            S_RUN: begin
               // Always N steps, even if the multiplier runs out of ones early.
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  product_q <= acc_d;
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_mant_mult_seq.sv
// Directed bench for mant_mult_seq: a vector table for N=32, hand-written
// sequences for the multi-cycle corner cases, and a small N=8 instance.
module tb_mant_mult_seq;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mant_mult_seq_if #(.N(32)) bus32 ();
   mant_mult_seq_if #(.N(8))  bus8 ();

   mant_mult_seq #(.N(32)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   mant_mult_seq #(.N(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] prod;
   } vec_t;

   int tests_run    = 0;
   int tests_failed = 0;
   int cout_hits32  = 0;
   int cout_hits8   = 0;

   // Adder carry-out must stay low for every RUN cycle of either instance.
   always @(negedge clk) begin
      if (rst_n && bus32.busy && !bus32.done && u_dut32.adder_cout_unused)
         cout_hits32 <= cout_hits32 + 1;
   end

   always @(negedge clk) begin
      if (rst_n && bus8.busy && !bus8.done && u_dut8.adder_cout_unused)
         cout_hits8 <= cout_hits8 + 1;
   end

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
      end else begin
         $display("[TB] ok %s = 0x%016h", name, act);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end else begin
         $display("[TB] ok %s = %0d", name, act);
      end
   endtask

   // Issue one op on the N=32 instance; called just after a falling edge.
   task automatic run32(input logic [31:0] av, input logic [31:0] bv,
                        output logic [63:0] prod, output int lat, output int busy_cycles);
      bus32.a     = av;
      bus32.b     = bv;
      bus32.start = 1'b1;
      @(negedge clk);
      bus32.start = 1'b0;
      lat         = -1;
      busy_cycles = 0;
      prod        = '0;
      for (int k = 1; k <= 200; k++) begin
         if (bus32.busy) busy_cycles++;
         if (bus32.done) begin
            lat  = k;
            prod = bus32.product;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   // Issue one op on the N=8 instance; called just after a falling edge.
   task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                       output logic [63:0] prod, output int lat);
      bus8.a     = av;
      bus8.b     = bv;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      lat        = -1;
      prod       = '0;
      for (int k = 1; k <= 100; k++) begin
         if (bus8.done) begin
            lat  = k;
            prod = bus8.product;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      vec_t        vecs [10];
      logic [63:0] prod;
      logic [63:0] prev;
      logic [63:0] got;
      logic [63:0] p1;
      logic [63:0] p2;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [7:0]  sa;
      logic [7:0]  sb;
      int          lat;
      int          bcyc;
      int          n_done;
      int          moved;
      int          first_k;
      int          k1;
      int          k2;

      vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[1] = '{32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000};
      vecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
      vecs[3] = '{32'h0000_0007, 32'h0000_0009, 64'h0000_0000_0000_003F};
      vecs[4] = '{32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006};
      vecs[5] = '{32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001};
      vecs[6] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
      vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
      vecs[8] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
      vecs[9] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};

      bus32.start = 1'b0;
      bus32.a     = '0;
      bus32.b     = '0;
      bus8.start  = 1'b0;
      bus8.a      = '0;
      bus8.b      = '0;

      // Reset asserted before any clock edge: outputs must clear immediately.
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_int("reset_busy", int'(bus32.busy), 0);
      check_int("reset_done", int'(bus32.done), 0);
      check64("reset_product", bus32.product, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table of directed operand pairs on the N=32 instance.
      for (int i = 0; i < 10; i++) begin
         run32(vecs[i].a, vecs[i].b, prod, lat, bcyc);
         check64($sformatf("vec%0d_product", i), prod, vecs[i].prod);
         check_int($sformatf("vec%0d_latency", i), lat, 33);
         check_int($sformatf("vec%0d_busy_cycles", i), bcyc, 33);
         check_int($sformatf("vec%0d_idle_after", i), int'(bus32.busy), 0);
      end

      // A start during RUN (with new operands) is dropped; operands may change freely.
      prev        = bus32.product;
      bus32.a     = 32'd7;
      bus32.b     = 32'd9;
      bus32.start = 1'b1;
      @(negedge clk);
      bus32.start = 1'b0;
      n_done  = 0;
      moved   = 0;
      first_k = -1;
      got     = '0;
      for (int k = 1; k <= 120; k++) begin
         if (k == 10) begin
            bus32.start = 1'b1;
            bus32.a     = 32'd3;
            bus32.b     = 32'd5;
         end
         if (k == 11) begin
            bus32.start = 1'b0;
            bus32.a     = 32'hFFFF_FFFF;
            bus32.b     = 32'hFFFF_FFFF;
         end
         if (bus32.done) begin
            n_done++;
            if (first_k < 0) begin
               first_k = k;
               got     = bus32.product;
            end
         end else if (bus32.busy && bus32.product !== prev) begin
            moved++;
         end
         @(negedge clk);
      end
      check64("drop_product", got, 64'd63);
      check_int("drop_done_pulses", n_done, 1);
      check_int("drop_latency", first_k, 33);
      check_int("drop_product_moved_in_run", moved, 0);

      // start held high: back-to-back operations every N+2 cycles.
      bus32.a     = 32'd2;
      bus32.b     = 32'd3;
      bus32.start = 1'b1;
      @(negedge clk);
      bus32.a = 32'd4;
      bus32.b = 32'd5;
      k1 = -1;
      k2 = -1;
      p1 = '0;
      p2 = '0;
      for (int k = 1; k <= 200; k++) begin
         if (k == 35) bus32.start = 1'b0;
         if (bus32.done) begin
            if (k1 < 0) begin
               k1 = k;
               p1 = bus32.product;
            end else if (k2 < 0) begin
               k2 = k;
               p2 = bus32.product;
            end
         end
         if (k2 >= 0) break;
         @(negedge clk);
      end
      bus32.start = 1'b0;
      @(negedge clk);
      check64("held_first_product", p1, 64'd6);
      check64("held_second_product", p2, 64'd20);
      check_int("held_first_latency", k1, 33);
      check_int("held_done_spacing", k2 - k1, 34);

      // Asynchronous reset mid-RUN aborts the op without a clock edge.
      bus32.a     = 32'h0000_FFFF;
      bus32.b     = 32'h0000_FFFF;
      bus32.start = 1'b1;
      @(negedge clk);
      bus32.start = 1'b0;
      for (int k = 1; k < 15; k++) @(negedge clk);
      check_int("midrun_busy_before_reset", int'(bus32.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check_int("async_reset_busy", int'(bus32.busy), 0);
      check_int("async_reset_done", int'(bus32.done), 0);
      check64("async_reset_product", bus32.product, 64'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      for (int k = 0; k < 60; k++) begin
         if (bus32.done) n_done++;
         @(negedge clk);
      end
      check_int("post_reset_no_done", n_done, 0);
      check64("post_reset_product_held", bus32.product, 64'h0);

      // First request after reset release is accepted normally.
      run32(32'd6, 32'd7, prod, lat, bcyc);
      check64("after_reset_product", prod, 64'd42);
      check_int("after_reset_latency", lat, 33);

      // A few pseudo-random operands on the N=32 instance against a*b.
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         run32(ra, rb, prod, lat, bcyc);
         check64($sformatf("rand32_%0d_%08h_x_%08h", i, ra, rb), prod, 64'(ra) * 64'(rb));
      end

      // N=8 instance: boundary operands, then random operands against a*b.
      run8(8'hFF, 8'hFF, prod, lat);
      check64("n8_ff_x_ff_product", prod, 64'h0000_0000_0000_FE01);
      check_int("n8_ff_x_ff_latency", lat, 9);
      for (int i = 0; i < 12; i++) begin
         sa = 8'($urandom_range(0, 255));
         sb = 8'($urandom_range(0, 255));
         run8(sa, sb, prod, lat);
         check64($sformatf("rand8_%0d_%02h_x_%02h", i, sa, sb), prod, 64'(sa) * 64'(sb));
         check_int($sformatf("rand8_%0d_latency", i), lat, 9);
      end

      check_int("adder_cout_hits_n32", cout_hits32, 0);
      check_int("adder_cout_hits_n8", cout_hits8, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/mant_mult_seq.md
MANT_MULT_SEQ -- requirements
Module: mant_mult_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the unsigned operand width; legal range 1..32 so the product fits in 64 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N bits: multiplicand, captured on the accepting edge.
REQ-006 The block SHALL have port b, input, N bits: multiplier, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle completion strobe.
REQ-009 The block SHALL have port product, output, 64 bits: registered result of the last completed operation.

Function
REQ-010 The block SHALL compute product = a*b (unsigned) by shift-and-add, instantiating exactly one RecursiveDoubling 64-bit adder as its only adder.
REQ-011 Internal registers SHALL be: mcand (64 b), mplier (N b), acc (64 b), cnt (6 b), state (IDLE, RUN, DONE).
REQ-012 In IDLE with start=1 at a rising edge: mcand <= zero-extended a, mplier <= b, acc <= 0, cnt <= 0, state <= RUN.
REQ-013 In IDLE with start=0: all registers hold.
REQ-014 Adder inputs SHALL be A=acc, B=mcand, permanently wired; the adder output is used only in RUN.
REQ-015 Each RUN edge: acc <= adder sum if mplier[0]=1, else acc holds; mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
REQ-016 RUN SHALL last exactly N edges, with no early termination on mplier=0; on the edge where cnt=N-1, product <= final acc and state <= DONE.
REQ-017 In DONE, done=1 for exactly one cycle; the next edge returns to IDLE.
REQ-018 Latency: with start accepted at edge E0, done is high in the cycle after edge EN and product is valid from that cycle.
REQ-019 Throughput: with start held high, the next operation is accepted at edge E(N+2), one operation per N+2 cycles.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing.
REQ-021 a and b changes after acceptance SHALL have no effect on the running operation.
REQ-022 product SHALL hold its value until the next completion; it SHALL NOT change during RUN.
REQ-023 Adder carry-out SHALL be unused; it is architecturally 0 for all legal N and operands.
REQ-024 done and busy SHALL be decoded from state registers only, never combinationally from start.

Reset
REQ-025 When rst_n=0, the block SHALL immediately, without a clock, set state=IDLE, busy=0, done=0, product=0, acc=0, mcand=0, mplier=0 and cnt=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; product SHALL read 0.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 Bench scenario: N=32, a=0xFFFFFFFF, b=0xFFFFFFFF, start pulse -> busy high for 33 cycles, done high in cycle 33 after the accepting edge, product=0xFFFFFFFE00000001.
REQ-029 Bench scenario: a=0x12345678, b=0 -> product=0 with full latency; a=0, b=0xDEADBEEF -> product=0.
REQ-030 Bench scenario: start pulsed with a=3, b=5 in RUN cycle 10 of an active 7*9 operation -> product=63, a single done pulse, second request dropped.
REQ-031 Bench scenario: start held high with (a,b)=(2,3) then (4,5) -> products 6 then 20, done pulses exactly 34 cycles apart.
REQ-032 Bench scenario: rst_n pulsed low asynchronously at RUN cycle 15 -> busy=0, done=0 and product=0 without a clock edge; no done pulse follows.
REQ-033 Bench scenario: N=8, a=0xFF, b=0xFF -> done 9 cycles after acceptance, product=0x000000000000FE01; random operands versus reference model, checking adder carry-out stays 0.
